axis_width_adapter: RTL and testbench
=====================================

AXIS_WIDTH_ADAPTER -- requirements
Module: axis_width_adapter

Interface
REQ-001 Parameter S_DATA_WIDTH, default 8, input tdata width in bits.
REQ-002 Parameter S_KEEP_ENABLE, default (S_DATA_WIDTH>8), use input tkeep; when 0, input tkeep is treated as all ones.
REQ-003 Parameter S_KEEP_WIDTH, default (S_DATA_WIDTH+7)/8, input tkeep width (words per beat).
REQ-004 Parameters M_DATA_WIDTH, M_KEEP_ENABLE and M_KEEP_WIDTH, defaults 8, (M_DATA_WIDTH>8) and (M_DATA_WIDTH+7)/8, are the output-side equivalents; when M_KEEP_ENABLE=0, output tkeep is driven all ones.
REQ-005 Parameters ID_ENABLE/ID_WIDTH (0/8), DEST_ENABLE/DEST_WIDTH (0/8) and USER_ENABLE/USER_WIDTH (1/1) each propagate the sideband when enabled; a disabled sideband output is driven to zero.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 s_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser  in  S_DATA_WIDTH/S_KEEP_WIDTH/1/1/ID_WIDTH/DEST_WIDTH/USER_WIDTH  input stream; s_axis_tready  out  1.
REQ-009 m_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser  out  M_DATA_WIDTH/M_KEEP_WIDTH/1/1/ID_WIDTH/DEST_WIDTH/USER_WIDTH  output stream; m_axis_tready  in  1.

Function
REQ-010 Word size = DATA_WIDTH/KEEP_WIDTH_INT, where KEEP_WIDTH_INT is the KEEP_WIDTH when keep is enabled and 1 otherwise; the word size shall be equal on both sides, and the keep-width ratio shall be an integer power of two.
REQ-011 A beat transfers when tvalid and tready are both 1; words are little-endian, so lane i = tdata[i*W +: W].
REQ-012 Equal keep widths: combinational pass-through of all signals with zero latency.
REQ-013 Upsize (M>S, N=M/S segments): accepted input beats fill output segments 0..N-1 in order.
REQ-014 An upsize output beat is presented one cycle after the beat that fills segment N-1 or carries tlast is accepted.
REQ-015 For a short final word, unfilled segments have tdata=0 and tkeep=0; output tlast equals the tlast of the closing input beat.
REQ-016 Upsize sidebands: tid and tdest come from the first segment of the output word; tuser comes from the closing beat.
REQ-017 Upsize: s_axis_tready=1 unless a completed output word is held unaccepted; when that word is accepted in the same cycle as the next input beat, both transfers occur with no bubble.
REQ-018 Downsize (S>M, N=S/M): an accepted input beat is registered, and its segments are emitted one per m_axis_tready cycle starting the next cycle.
REQ-019 Downsize segment skipping: segments after the first whose tkeep is all zero are skipped; tlast is asserted on the last non-empty segment only when the input tlast=1.
REQ-020 Downsize sidebands: tid, tdest and tuser are replicated on every output beat.
REQ-021 Downsize: s_axis_tready=1 when the buffer is empty or its final segment is being accepted this cycle, giving back-to-back throughput.
REQ-022 Output data and sideband signals shall hold stable while m_axis_tvalid=1 and m_axis_tready=0.

Reset
REQ-023 With rst=1: m_axis_tvalid=0, m_axis_tlast=0, data/keep/sidebands=0, segment counters=0, and any partial word is discarded.
REQ-024 After rst falls: s_axis_tready=1 from the first clock in upsize and downsize modes.

Configuration
REQ-025 Macro AXIS_WIDTH_ADAPTER_PARAM_CHECK_EN defined: elaboration-time checks of REQ-010 shall emit an error and stop simulation on violation.
REQ-026 Macro undefined: no checks are compiled, and the hardware is identical.

Verification
REQ-027 S=8,M=32: bytes 11,22,33,44 with tlast on 44 -> one beat tdata=0x44332211, tkeep=1111, tlast=1.
REQ-028 S=8,M=32: bytes AA,BB,CC with tlast on CC -> tdata=0x00CCBBAA, tkeep=0111, tlast=1.
REQ-029 S=32,M=8: tdata=0xDDCCBBAA, tkeep=0011, tlast=1 -> beats AA then BB, tlast only on BB, 2 cycles.
REQ-030 S=32,M=8 with m_axis_tready toggling 1,0,1,0: output stable while stalled; s_axis_tready=0 until the last segment is accepted.
REQ-031 rst pulsed mid-frame (2 of 4 bytes sent, S=8,M=32): m_axis_tvalid=0 immediately, and the next frame 01..04 -> 0x04030201 with no leftover data.
REQ-032 S=M=32: input 0x12345678 -> same-cycle output identical, with tready passed through.

Source files
------------

// File: rtl/axis_width_adapter.sv
// AXI4-Stream width adapter: pass-through, upsize (segment packing) or downsize (segment emission).
// Optional elaboration checks of word size / ratio under AXIS_WIDTH_ADAPTER_PARAM_CHECK_EN.
module axis_width_adapter #(
  parameter int S_DATA_WIDTH  = 8,
  parameter int S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
  parameter int S_KEEP_WIDTH  = (S_DATA_WIDTH + 7) / 8,
  parameter int M_DATA_WIDTH  = 8,
  parameter int M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
  parameter int M_KEEP_WIDTH  = (M_DATA_WIDTH + 7) / 8,
  parameter int ID_ENABLE     = 0,
  parameter int ID_WIDTH      = 8,
  parameter int DEST_ENABLE   = 0,
  parameter int DEST_WIDTH    = 8,
  parameter int USER_ENABLE   = 1,
  parameter int USER_WIDTH    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser
);

  localparam int SKW = (S_KEEP_ENABLE != 0) ? S_KEEP_WIDTH : 1;
  localparam int MKW = (M_KEEP_ENABLE != 0) ? M_KEEP_WIDTH : 1;

`ifdef AXIS_WIDTH_ADAPTER_PARAM_CHECK_EN
  localparam int BigKw   = (SKW > MKW) ? SKW : MKW;
  localparam int SmallKw = (SKW > MKW) ? MKW : SKW;
  localparam int Ratio   = BigKw / SmallKw;
  if (S_DATA_WIDTH / SKW != M_DATA_WIDTH / MKW) begin : g_chk_word
    $fatal(1, "axis_width_adapter: word size differs between input and output");
  end
  if ((BigKw % SmallKw != 0) || ((Ratio & (Ratio - 1)) != 0)) begin : g_chk_ratio
    $fatal(1, "axis_width_adapter: keep-width ratio is not a power of two");
  end
`endif

  logic [SKW-1:0]          s_keep;
  logic [M_DATA_WIDTH-1:0] m_data;
  logic [MKW-1:0]          m_keep;
  logic                    m_valid, m_last, s_ready;
  logic [ID_WIDTH-1:0]     m_id;
  logic [DEST_WIDTH-1:0]   m_dest;
  logic [USER_WIDTH-1:0]   m_user;

  if (S_KEEP_ENABLE != 0) begin : g_s_keep
    assign s_keep = s_axis_tkeep;
  end else begin : g_s_keep_ones
    assign s_keep = '1;
  end

  if (M_KEEP_ENABLE != 0) begin : g_m_keep
    assign m_axis_tkeep = m_keep;
  end else begin : g_m_keep_ones
    assign m_axis_tkeep = '1;
  end

  assign m_axis_tdata  = m_data;
  assign m_axis_tvalid = m_valid;
  assign m_axis_tlast  = m_last;
  assign m_axis_tid    = (ID_ENABLE != 0) ? m_id : '0;
  assign m_axis_tdest  = (DEST_ENABLE != 0) ? m_dest : '0;
  assign m_axis_tuser  = (USER_ENABLE != 0) ? m_user : '0;
  assign s_axis_tready = s_ready;

  // Collects inputs that some configurations leave unread.
  logic unused_keep;
  assign unused_keep = ^{s_axis_tkeep, m_keep};

  if (SKW == MKW) begin : g_pass
    assign m_data  = s_axis_tdata;
    assign m_keep  = s_keep;
    assign m_valid = s_axis_tvalid;
    assign m_last  = s_axis_tlast;
    assign m_id    = s_axis_tid;
    assign m_dest  = s_axis_tdest;
    assign m_user  = s_axis_tuser;
    assign s_ready = m_axis_tready;

  end else if (MKW > SKW) begin : g_up
    localparam int N  = MKW / SKW;
    localparam int CW = $clog2(N);

    logic [CW-1:0]           seg_cnt_q;
    logic [M_DATA_WIDTH-1:0] acc_data_q, out_data_q, up_data;
    logic [MKW-1:0]          acc_keep_q, out_keep_q, up_keep;
    logic [ID_WIDTH-1:0]     acc_id_q, out_id_q, up_id;
    logic [DEST_WIDTH-1:0]   acc_dest_q, out_dest_q, up_dest;
    logic [USER_WIDTH-1:0]   out_user_q;
    logic                    out_valid_q, out_last_q, closing;

    // Accumulator merged with the incoming beat; higher segments stay zero.
    always_comb begin
      up_data = acc_data_q;
      up_keep = acc_keep_q;
      up_data[seg_cnt_q*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
      up_keep[seg_cnt_q*SKW +: SKW] = s_keep;
      up_id   = (seg_cnt_q == '0) ? s_axis_tid : acc_id_q;
      up_dest = (seg_cnt_q == '0) ? s_axis_tdest : acc_dest_q;
    end

    assign closing = (seg_cnt_q == CW'(N - 1)) || s_axis_tlast;
    assign s_ready = !out_valid_q || m_axis_tready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        seg_cnt_q   <= '0;
        acc_data_q  <= '0;
        acc_keep_q  <= '0;
        acc_id_q    <= '0;
        acc_dest_q  <= '0;
        out_data_q  <= '0;
        out_keep_q  <= '0;
        out_id_q    <= '0;
        out_dest_q  <= '0;
        out_user_q  <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        if (out_valid_q && m_axis_tready) out_valid_q <= 1'b0;
        if (s_axis_tvalid && s_ready) begin
          if (closing) begin
            out_data_q  <= up_data;
            out_keep_q  <= up_keep;
            out_id_q    <= up_id;
            out_dest_q  <= up_dest;
            out_user_q  <= s_axis_tuser;
            out_last_q  <= s_axis_tlast;
            out_valid_q <= 1'b1;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            seg_cnt_q   <= '0;
          end else begin
            acc_data_q <= up_data;
            acc_keep_q <= up_keep;
            acc_id_q   <= up_id;
            acc_dest_q <= up_dest;
            seg_cnt_q  <= seg_cnt_q + CW'(1);
          end
        end
      end
    end

    assign m_data  = out_data_q;
    assign m_keep  = out_keep_q;
    assign m_valid = out_valid_q;
    assign m_last  = out_last_q;
    assign m_id    = out_id_q;
    assign m_dest  = out_dest_q;
    assign m_user  = out_user_q;

  end else begin : g_down
    localparam int N  = SKW / MKW;
    localparam int CW = $clog2(N);

    logic [CW-1:0]           seg_q, next_seg;
    logic [S_DATA_WIDTH-1:0] buf_data_q;
    logic [SKW-1:0]          buf_keep_q;
    logic [ID_WIDTH-1:0]     buf_id_q;
    logic [DEST_WIDTH-1:0]   buf_dest_q;
    logic [USER_WIDTH-1:0]   buf_user_q;
    logic                    buf_valid_q, buf_last_q, has_next;

    // Nearest later segment with any keep bit set; none means this is the final one.
    always_comb begin
      has_next = 1'b0;
      next_seg = seg_q;
      for (int i = N - 1; i >= 0; i--) begin
        if (i > int'(seg_q) && (|buf_keep_q[i*MKW +: MKW])) begin
          has_next = 1'b1;
          next_seg = CW'(i);
        end
      end
    end

    assign s_ready = !buf_valid_q || (m_axis_tready && !has_next);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        seg_q       <= '0;
        buf_data_q  <= '0;
        buf_keep_q  <= '0;
        buf_id_q    <= '0;
        buf_dest_q  <= '0;
        buf_user_q  <= '0;
        buf_last_q  <= 1'b0;
        buf_valid_q <= 1'b0;
      end else if (s_axis_tvalid && s_ready) begin
        seg_q       <= '0;
        buf_data_q  <= s_axis_tdata;
        buf_keep_q  <= s_keep;
        buf_id_q    <= s_axis_tid;
        buf_dest_q  <= s_axis_tdest;
        buf_user_q  <= s_axis_tuser;
        buf_last_q  <= s_axis_tlast;
        buf_valid_q <= 1'b1;
      end else if (buf_valid_q && m_axis_tready) begin
        if (has_next) seg_q <= next_seg;
        else buf_valid_q <= 1'b0;
      end
    end

    assign m_data  = buf_data_q[seg_q*M_DATA_WIDTH +: M_DATA_WIDTH];
    assign m_keep  = buf_keep_q[seg_q*MKW +: MKW];
    assign m_valid = buf_valid_q;
    assign m_last  = buf_last_q && !has_next;
    assign m_id    = buf_id_q;
    assign m_dest  = buf_dest_q;
    assign m_user  = buf_user_q;
  end

endmodule

// File: tb/tb_axis_width_adapter.sv
// Directed bench for axis_width_adapter: 8->32 upsize, 32->8 downsize and 32->32 pass-through.
module tb_axis_width_adapter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Upsize 8 -> 32 with tid enabled
  logic [7:0]  u_sdata, u_sid, u_sdest, u_mid, u_mdest;
  logic        u_skeep, u_svalid, u_sready, u_slast, u_suser;
  logic [31:0] u_mdata;
  logic [3:0]  u_mkeep;
  logic        u_mvalid, u_mready, u_mlast, u_muser;

  // Downsize 32 -> 8
  logic [31:0] d_sdata;
  logic [3:0]  d_skeep;
  logic [7:0]  d_sid, d_sdest, d_mid, d_mdest, d_mdata;
  logic        d_svalid, d_sready, d_slast, d_suser;
  logic        d_mkeep, d_mvalid, d_mready, d_mlast, d_muser;

  // Equal 32 -> 32
  logic [31:0] e_sdata, e_mdata;
  logic [3:0]  e_skeep, e_mkeep;
  logic [7:0]  e_sid, e_sdest, e_mid, e_mdest;
  logic        e_svalid, e_sready, e_slast, e_suser;
  logic        e_mvalid, e_mready, e_mlast, e_muser;

  axis_width_adapter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32), .ID_ENABLE(1)) u_up (
    .clk(clk), .rst(rst),
    .s_axis_tdata(u_sdata), .s_axis_tkeep(u_skeep), .s_axis_tvalid(u_svalid),
    .s_axis_tready(u_sready), .s_axis_tlast(u_slast), .s_axis_tid(u_sid),
    .s_axis_tdest(u_sdest), .s_axis_tuser(u_suser),
    .m_axis_tdata(u_mdata), .m_axis_tkeep(u_mkeep), .m_axis_tvalid(u_mvalid),
    .m_axis_tready(u_mready), .m_axis_tlast(u_mlast), .m_axis_tid(u_mid),
    .m_axis_tdest(u_mdest), .m_axis_tuser(u_muser)
  );

  axis_width_adapter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8)) u_dn (
    .clk(clk), .rst(rst),
    .s_axis_tdata(d_sdata), .s_axis_tkeep(d_skeep), .s_axis_tvalid(d_svalid),
    .s_axis_tready(d_sready), .s_axis_tlast(d_slast), .s_axis_tid(d_sid),
    .s_axis_tdest(d_sdest), .s_axis_tuser(d_suser),
    .m_axis_tdata(d_mdata), .m_axis_tkeep(d_mkeep), .m_axis_tvalid(d_mvalid),
    .m_axis_tready(d_mready), .m_axis_tlast(d_mlast), .m_axis_tid(d_mid),
    .m_axis_tdest(d_mdest), .m_axis_tuser(d_muser)
  );

  axis_width_adapter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(32)) u_eq (
    .clk(clk), .rst(rst),
    .s_axis_tdata(e_sdata), .s_axis_tkeep(e_skeep), .s_axis_tvalid(e_svalid),
    .s_axis_tready(e_sready), .s_axis_tlast(e_slast), .s_axis_tid(e_sid),
    .s_axis_tdest(e_sdest), .s_axis_tuser(e_suser),
    .m_axis_tdata(e_mdata), .m_axis_tkeep(e_mkeep), .m_axis_tvalid(e_mvalid),
    .m_axis_tready(e_mready), .m_axis_tlast(e_mlast), .m_axis_tid(e_mid),
    .m_axis_tdest(e_mdest), .m_axis_tuser(e_muser)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        valid, last, user, mready;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_valid, exp_last, exp_user, exp_sready;
  } eq_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic up_beat(input logic [7:0] d, input logic l, input logic [7:0] id,
                         input logic usr);
    u_sdata = d; u_slast = l; u_sid = id; u_suser = usr; u_svalid = 1'b1;
    cyc();
    u_svalid = 1'b0; u_slast = 1'b0;
  endtask

  task automatic dn_load(input logic [31:0] d, input logic [3:0] k, input logic l,
                         input logic usr);
    d_sdata = d; d_skeep = k; d_slast = l; d_suser = usr; d_svalid = 1'b1;
    cyc();
    d_svalid = 1'b0;
  endtask

  eq_vec_t eqv[4];
  logic [31:0] word;
  int seg;

  initial begin
    eqv[0] = '{32'h12345678, 4'hF, 1, 1, 1, 1, 32'h12345678, 4'hF, 1, 1, 1, 1};
    eqv[1] = '{32'h12345678, 4'hF, 1, 1, 0, 0, 32'h12345678, 4'hF, 1, 1, 0, 0};
    eqv[2] = '{32'hCAFEBABE, 4'h3, 1, 0, 1, 1, 32'hCAFEBABE, 4'h3, 1, 0, 1, 1};
    eqv[3] = '{32'h0000_00FF, 4'h1, 0, 0, 0, 1, 32'h0000_00FF, 4'h1, 0, 0, 0, 1};

    {u_sdata, u_sid, u_sdest, u_skeep, u_svalid, u_slast, u_suser} = '0;
    {d_sdata, d_skeep, d_sid, d_sdest, d_svalid, d_slast, d_suser} = '0;
    {e_sdata, e_skeep, e_sid, e_sdest, e_svalid, e_slast, e_suser} = '0;
    u_mready = 1'b1; d_mready = 1'b1; e_mready = 1'b0;

    // Reset state
    repeat (2) cyc();
    check("rst_up_out", {u_mvalid, u_mlast, u_mdata, u_mkeep, u_mid}, '0);
    check("rst_dn_out", {d_mvalid, d_mlast, d_mdata, d_mid}, '0);
    rst = 1'b0;
    cyc();
    check("rst_readies", {u_sready, d_sready}, 2'b11);

    // Pass-through table
    for (int i = 0; i < 4; i++) begin
      e_sdata = eqv[i].data; e_skeep = eqv[i].keep; e_svalid = eqv[i].valid;
      e_slast = eqv[i].last; e_suser = eqv[i].user; e_mready = eqv[i].mready;
      #1;
      check($sformatf("eq_vec%0d", i),
            {e_mdata, e_mkeep, e_mvalid, e_mlast, e_muser, e_sready},
            {eqv[i].exp_data, eqv[i].exp_keep, eqv[i].exp_valid, eqv[i].exp_last,
             eqv[i].exp_user, eqv[i].exp_sready});
    end

    // Upsize full word: 11 22 33 44
    up_beat(8'h11, 0, 8'h05, 0);
    up_beat(8'h22, 0, 8'h06, 0);
    up_beat(8'h33, 0, 8'h06, 0);
    check("up_not_early", u_mvalid, 1'b0);
    up_beat(8'h44, 1, 8'h06, 1);
    check("up_full", {u_mvalid, u_mdata, u_mkeep, u_mlast, u_mid, u_muser},
          {1'b1, 32'h44332211, 4'hF, 1'b1, 8'h05, 1'b1});
    cyc();
    check("up_full_drained", u_mvalid, 1'b0);

    // Upsize short word: AA BB CC
    up_beat(8'hAA, 0, 8'h01, 1);
    up_beat(8'hBB, 0, 8'h02, 0);
    up_beat(8'hCC, 1, 8'h03, 0);
    check("up_short", {u_mvalid, u_mdata, u_mkeep, u_mlast, u_mid, u_muser},
          {1'b1, 32'h00CCBBAA, 4'h7, 1'b1, 8'h01, 1'b0});
    cyc();

    // Upsize backpressure and bubble-free handover
    u_mready = 1'b0;
    up_beat(8'h01, 0, 8'h00, 0);
    up_beat(8'h02, 0, 8'h00, 0);
    up_beat(8'h03, 0, 8'h00, 0);
    up_beat(8'h04, 1, 8'h00, 0);
    u_sdata = 8'h55; u_sid = 8'h09; u_slast = 1'b0; u_svalid = 1'b1;
    #1;
    check("up_held_sready", u_sready, 1'b0);
    cyc();
    check("up_held_stable", {u_mvalid, u_mdata, u_mlast}, {1'b1, 32'h04030201, 1'b1});
    u_mready = 1'b1;
    #1;
    check("up_release_sready", u_sready, 1'b1);
    cyc();
    u_svalid = 1'b0;
    check("up_release_drained", u_mvalid, 1'b0);
    up_beat(8'h66, 0, 8'h0A, 0);
    up_beat(8'h77, 0, 8'h0A, 0);
    up_beat(8'h88, 1, 8'h0A, 0);
    check("up_no_bubble", {u_mvalid, u_mdata, u_mkeep, u_mid},
          {1'b1, 32'h88776655, 4'hF, 8'h09});
    cyc();

    // Reset mid-frame discards partial word
    up_beat(8'hA1, 0, 8'h00, 0);
    up_beat(8'hA2, 0, 8'h00, 0);
    rst = 1'b1;
    #1;
    check("up_rst_mid", {u_mvalid, u_mdata}, '0);
    cyc();
    rst = 1'b0;
    cyc();
    up_beat(8'h01, 0, 8'h00, 0);
    up_beat(8'h02, 0, 8'h00, 0);
    up_beat(8'h03, 0, 8'h00, 0);
    up_beat(8'h04, 1, 8'h00, 0);
    check("up_after_rst", {u_mvalid, u_mdata, u_mkeep, u_mlast},
          {1'b1, 32'h04030201, 4'hF, 1'b1});
    cyc();

    // Downsize with two kept bytes
    dn_load(32'hDDCCBBAA, 4'b0011, 1, 1);
    check("dn_seg0", {d_mvalid, d_mdata, d_mkeep, d_mlast, d_muser, d_sready},
          {1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0});
    cyc();
    check("dn_seg1", {d_mvalid, d_mdata, d_mlast, d_muser, d_sready},
          {1'b1, 8'hBB, 1'b1, 1'b1, 1'b1});
    cyc();
    check("dn_done", d_mvalid, 1'b0);

    // Downsize with m_axis_tready toggling
    word = 32'h44332211;
    dn_load(word, 4'hF, 1, 0);
    seg = 0;
    for (int c = 0; c < 7; c++) begin
      d_mready = (c % 2 == 0);
      #1;
      check($sformatf("dn_toggle%0d", c), {d_mvalid, d_mdata, d_mlast, d_sready},
            {1'b1, word[seg*8 +: 8], seg == 3, (seg == 3) && d_mready});
      @(posedge clk);
      if (d_mready) seg++;
      #1;
    end
    d_mready = 1'b1;
    #1;
    check("dn_toggle_done", {d_mvalid, 32'(seg)}, {1'b0, 32'd4});

    // Sparse keep skips empty segments, next beat loads back-to-back
    dn_load(word, 4'b0101, 1, 0);
    check("dn_sparse0", {d_mvalid, d_mdata, d_mlast}, {1'b1, 8'h11, 1'b0});
    cyc();
    check("dn_sparse2", {d_mvalid, d_mdata, d_mlast, d_sready}, {1'b1, 8'h33, 1'b1, 1'b1});
    dn_load(32'h000000EE, 4'b0001, 0, 0);
    check("dn_b2b", {d_mvalid, d_mdata, d_mlast}, {1'b1, 8'hEE, 1'b0});
    cyc();
    check("dn_b2b_done", d_mvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
